sd_block_mover: RTL and testbench
=================================

Name: sd_block_mover

Overview:
- Backend stage directly downstream of sd_link's block request outputs.
- Services single- and multi-block reads by filling the 128x32 read buffer from backing memory, then pulsing block_read_go.
- Services writes by draining the 128x32 write buffer to memory after a block lands, then pulsing block_write_done.
- Runs in the sys_clk domain, the same domain as sd_link.

Parameters:
- MEM_AW, 30, word-address width of the memory port.
- BASE_WORD, 0, word offset of block 0 in memory.
- NUM_BLOCKS, 32'h0001_0000, card capacity in 512-byte blocks; a block number >= NUM_BLOCKS is out of range.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  asynchronous, active-high reset.
- block_read_act  in  1  link requests read service.
- block_read_addr  in  32  first block number.
- block_read_stop  in  1  abort multi-block read.
- block_read_next  in  1  pulse: read buffer consumed, fetch next block.
- block_read_go  out  1  pulse: read buffer valid.
- block_write_act  in  1  link requests write service.
- block_write_addr  in  32  first block number.
- block_write_ready  in  1  pulse: write buffer holds a complete, CRC-good block.
- block_write_done  out  1  pulse: block committed to memory.
- rdbuf_adr  out  7, rdbuf_dat_w  out  32, rdbuf_we  out  1  read-buffer write port.
- wrbuf_adr  out  7  write-buffer address.
- wrbuf_dat_r  in  32  write-buffer data; registered, 1-cycle read latency.
- mem_req  out  1, mem_we  out  1, mem_adr  out  MEM_AW, mem_dat_w  out  32  memory request.
- mem_dat_r  in  32, mem_ack  in  1  memory response.
- err_out_range  out  1  pulse: out-of-range block.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; block index 0; word counter 0.
- Addressing: word address = BASE_WORD + (blk<<7) + i, truncated to MEM_AW; blk = start address + block index.
- Memory handshake:
  - mem_req is registered; mem_adr, mem_we and mem_dat_w stay stable while mem_req=1.
  - mem_ack is sampled only while mem_req=1; the transaction ends in the ack cycle and mem_req drops the next cycle.
- IDLE:
  - block_read_act -> RD_REQ, index=0.
  - Otherwise block_write_act -> WR_WAIT, index=0.
  - Both active: read wins.
- Reads:
  - RD_REQ/RD_WAIT: word i requested. In the ack cycle, rdbuf_we=1, rdbuf_adr=i, rdbuf_dat_w=mem_dat_r.
  - After word 127 -> RD_GO: block_read_go=1 for exactly one cycle -> RD_HOLD.
  - RD_HOLD: block_read_stop or !block_read_act -> IDLE. Otherwise block_read_next -> index+1, i=0, RD_REQ.
  - Stop or act-drop during fill: the outstanding transaction completes (await ack), then IDLE; no go pulse.
  - Out-of-range blk: no memory access. 128 zero words are written to rdbuf (1/cycle), err_out_range and block_read_go pulse together, then RD_HOLD.
  - Best-case fill latency: 128 x (1 req + ack delay) cycles.
- Writes:
  - WR_WAIT: block_write_ready -> WR_FETCH, i=0. !block_write_act -> IDLE.
  - WR_FETCH drives wrbuf_adr=i; data is valid next cycle and latched into mem_dat_w.
  - WR_REQ: mem_req=1, mem_we=1 until ack.
  - After word 127: block_write_done pulses 1 cycle, index+1, back to WR_WAIT.
  - Act-drop mid-drain: the current block is finished, then IDLE.
  - Out-of-range: no memory access; done and err_out_range pulse together 1 cycle after ready.
- block_write_ready arriving when not in WR_WAIT is ignored.
- Index wraps at 2^32; no saturation.

Optional Feature:
- Macro: SD_BLOCK_BYTESWAP_EN.
- Defined: every 32-bit word is byte-reversed between memory and buffer in both directions (rdbuf_dat_w = bswap(mem_dat_r); mem_dat_w = bswap(wrbuf_dat_r)).
- Undefined: words pass unchanged. Timing is identical either way.

Decomposition:
- Package sd_block_pkg holds:
  - state enum;
  - WORDS_PER_BLOCK=128, WORD_IDX_W=7;
  - bswap32 function.
- One sub-module, sd_block_memif: owns the mem_req/ack handshake register, address compute and the optional byteswap. The FSM stays in sd_block_mover.

Test Plan:
- Read block 5, BASE_WORD=0, memory word k = k, ack delay 2:
  - rdbuf[i] = 640+i for i=0..127;
  - exactly one go pulse;
  - mem_adr spans 640..767.
- Multi-block read from block 2 with two block_read_next pulses, then stop:
  - three go pulses;
  - buffer contents track blocks 2, 3 and 4;
  - returns to IDLE, busy=0.
- Write to block 1; wrbuf[i] = 32'hA500_0000+i; pulse ready:
  - memory words 128..255 hold the pattern;
  - one done pulse;
  - mem_we=1 throughout.
- Read at block NUM_BLOCKS:
  - no mem_req;
  - rdbuf all zero;
  - err_out_range and go coincide.
- Assert sys_rst during RD_WAIT of word 60:
  - all outputs 0 immediately (asynchronous);
  - after release, a fresh read restarts at word 0.
- SD_BLOCK_BYTESWAP_EN defined, mem word 32'h11223344:
  - rdbuf receives 32'h44332211;
  - the write path reverses symmetrically.

Source files
------------

// File: rtl/sd_block_pkg.sv
// Shared definitions for the SD block mover: FSM states, block geometry and
// the 32-bit byte-reversal helper used by the optional byte-swap path.
package sd_block_pkg;

  localparam int WORDS_PER_BLOCK = 128;
  localparam int WORD_IDX_W      = 7;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_RD_ZERO,
    ST_RD_GO,
    ST_RD_HOLD,
    ST_WR_WAIT,
    ST_WR_FETCH,
    ST_WR_ISSUE,
    ST_WR_REQ,
    ST_WR_DONE
  } state_t;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/sd_block_memif.sv
// Memory-port side of the block mover: request/ack handshake register, word
// address generation and the optional byte swap (SD_BLOCK_BYTESWAP_EN).
module sd_block_memif
  import sd_block_pkg::*;
#(
  parameter int              MEM_AW    = 30,
  parameter longint unsigned BASE_WORD = 0
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  start,
  input  logic                  start_we,
  input  logic [31:0]           blk,
  input  logic [WORD_IDX_W-1:0] word,
  input  logic                  wdata_load,
  input  logic [31:0]           wrbuf_dat_r,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [MEM_AW-1:0]     mem_adr,
  output logic [31:0]           mem_dat_w,
  input  logic [31:0]           mem_dat_r,
  input  logic                  mem_ack,
  output logic                  ack,
  output logic [31:0]           rdata
);

  logic              mem_req_reg;
  logic              mem_we_reg;
  logic [MEM_AW-1:0] mem_adr_reg;
  logic [31:0]       mem_dat_w_reg;
  logic [MEM_AW-1:0] word_addr;
  logic [31:0]       wdata_conv;

  // Truncation to MEM_AW bits happens term by term; sum is identical modulo 2^MEM_AW.
  assign word_addr = MEM_AW'(BASE_WORD) + MEM_AW'({blk, 7'd0}) + MEM_AW'(word);

`ifdef SD_BLOCK_BYTESWAP_EN
  assign rdata      = bswap32(mem_dat_r);
  assign wdata_conv = bswap32(wrbuf_dat_r);
`else
  assign rdata      = mem_dat_r;
  assign wdata_conv = wrbuf_dat_r;
`endif

  assign ack = mem_req_reg & mem_ack;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_adr_reg   <= '0;
      mem_dat_w_reg <= '0;
    end else begin
      if (start) begin
        mem_req_reg <= 1'b1;
        mem_we_reg  <= start_we;
        mem_adr_reg <= word_addr;
      end else if (ack) begin
        mem_req_reg <= 1'b0;
        mem_we_reg  <= 1'b0;
      end
      if (wdata_load) begin
        mem_dat_w_reg <= wdata_conv;
      end
    end
  end

  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_adr   = mem_adr_reg;
  assign mem_dat_w = mem_dat_w_reg;

endmodule

// File: rtl/sd_block_mover.sv
// Moves 512-byte blocks between the SD link buffers and backing memory.
// Optional word byte reversal is enabled by defining SD_BLOCK_BYTESWAP_EN.
module sd_block_mover
  import sd_block_pkg::*;
#(
  parameter int              MEM_AW     = 30,
  parameter longint unsigned BASE_WORD  = 0,
  parameter logic [31:0]     NUM_BLOCKS = 32'h0001_0000
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              block_read_act,
  input  logic [31:0]       block_read_addr,
  input  logic              block_read_stop,
  input  logic              block_read_next,
  output logic              block_read_go,
  input  logic              block_write_act,
  input  logic [31:0]       block_write_addr,
  input  logic              block_write_ready,
  output logic              block_write_done,
  output logic [6:0]        rdbuf_adr,
  output logic [31:0]       rdbuf_dat_w,
  output logic              rdbuf_we,
  output logic [6:0]        wrbuf_adr,
  input  logic [31:0]       wrbuf_dat_r,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_adr,
  output logic [31:0]       mem_dat_w,
  input  logic [31:0]       mem_dat_r,
  input  logic              mem_ack,
  output logic              err_out_range,
  output logic              busy
);

  state_t                state_reg, state_next;
  logic [31:0]           start_reg, start_next;
  logic [31:0]           index_reg, index_next;
  logic [WORD_IDX_W-1:0] word_reg, word_next;
  logic                  abort_reg, abort_next;

  logic [31:0] blk;
  logic        blk_oor, last_word, rd_cancel;
  logic        mif_start, mif_start_we, mif_load, mif_ack;
  logic [31:0] mif_rdata;

  assign blk       = start_reg + index_reg;
  assign blk_oor   = (blk >= NUM_BLOCKS);
  assign last_word = (word_reg == WORD_IDX_W'(WORDS_PER_BLOCK - 1));
  assign rd_cancel = block_read_stop | ~block_read_act;

  sd_block_memif #(
    .MEM_AW    (MEM_AW),
    .BASE_WORD (BASE_WORD)
  ) u_memif (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .start       (mif_start),
    .start_we    (mif_start_we),
    .blk         (blk),
    .word        (word_reg),
    .wdata_load  (mif_load),
    .wrbuf_dat_r (wrbuf_dat_r),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_adr     (mem_adr),
    .mem_dat_w   (mem_dat_w),
    .mem_dat_r   (mem_dat_r),
    .mem_ack     (mem_ack),
    .ack         (mif_ack),
    .rdata       (mif_rdata)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg <= ST_IDLE;
      start_reg <= '0;
      index_reg <= '0;
      word_reg  <= '0;
      abort_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      start_reg <= start_next;
      index_reg <= index_next;
      word_reg  <= word_next;
      abort_reg <= abort_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    start_next       = start_reg;
    index_next       = index_reg;
    word_next        = word_reg;
    abort_next       = abort_reg;
    mif_start        = 1'b0;
    mif_start_we     = 1'b0;
    mif_load         = 1'b0;
    rdbuf_we         = 1'b0;
    rdbuf_dat_w      = '0;
    block_read_go    = 1'b0;
    block_write_done = 1'b0;
    err_out_range    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        index_next = '0;
        word_next  = '0;
        abort_next = 1'b0;
        if (block_read_act) begin
          start_next = block_read_addr;
          state_next = ST_RD_REQ;
        end else if (block_write_act) begin
          start_next = block_write_addr;
          state_next = ST_WR_WAIT;
        end
      end
      ST_RD_REQ: begin
        if (rd_cancel) begin
          state_next = ST_IDLE;
        end else if (blk_oor) begin
          state_next = ST_RD_ZERO;
        end else begin
          mif_start  = 1'b1;
          state_next = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        // A cancel seen while waiting is remembered; the bus cycle must still finish.
        if (rd_cancel) abort_next = 1'b1;
        if (mif_ack) begin
          rdbuf_we    = 1'b1;
          rdbuf_dat_w = mif_rdata;
          if (abort_reg || rd_cancel) begin
            state_next = ST_IDLE;
          end else if (last_word) begin
            state_next = ST_RD_GO;
          end else begin
            word_next  = word_reg + 1'b1;
            state_next = ST_RD_REQ;
          end
        end
      end
      ST_RD_ZERO: begin
        rdbuf_we = 1'b1;
        if (rd_cancel) begin
          state_next = ST_IDLE;
        end else if (last_word) begin
          state_next = ST_RD_GO;
        end else begin
          word_next = word_reg + 1'b1;
        end
      end
      ST_RD_GO: begin
        block_read_go = 1'b1;
        err_out_range = blk_oor;
        state_next    = ST_RD_HOLD;
      end
      ST_RD_HOLD: begin
        if (rd_cancel) begin
          state_next = ST_IDLE;
        end else if (block_read_next) begin
          index_next = index_reg + 1'b1;
          word_next  = '0;
          state_next = ST_RD_REQ;
        end
      end
      ST_WR_WAIT: begin
        if (block_write_ready) begin
          word_next  = '0;
          state_next = blk_oor ? ST_WR_DONE : ST_WR_FETCH;
        end else if (!block_write_act) begin
          state_next = ST_IDLE;
        end
      end
      ST_WR_FETCH: state_next = ST_WR_ISSUE;
      ST_WR_ISSUE: begin
        mif_start    = 1'b1;
        mif_start_we = 1'b1;
        mif_load     = 1'b1;
        state_next   = ST_WR_REQ;
      end
      ST_WR_REQ: begin
        if (mif_ack) begin
          if (last_word) begin
            state_next = ST_WR_DONE;
          end else begin
            word_next  = word_reg + 1'b1;
            state_next = ST_WR_FETCH;
          end
        end
      end
      ST_WR_DONE: begin
        block_write_done = 1'b1;
        err_out_range    = blk_oor;
        index_next       = index_reg + 1'b1;
        state_next       = block_write_act ? ST_WR_WAIT : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign rdbuf_adr = word_reg;
  assign wrbuf_adr = word_reg;
  assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_sd_block_mover.sv
// Directed bench for sd_block_mover: memory/buffer models plus a per-cycle
// compare against block-level expectations derived from the block map.
module tb_sd_block_mover;

  localparam int              MEM_AW    = 12;
  localparam int              MEM_WORDS = 4096;
  localparam longint unsigned BASE      = 0;
  localparam int              ACK_DLY   = 2;
`ifdef SD_BLOCK_BYTESWAP_EN
  localparam logic [31:0] EXP_SW = 32'h4433_2211;
`else
  localparam logic [31:0] EXP_SW = 32'h1122_3344;
`endif

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic              block_read_act, block_read_stop, block_read_next, block_read_go;
  logic [31:0]       block_read_addr;
  logic              block_write_act, block_write_ready, block_write_done;
  logic [31:0]       block_write_addr;
  logic [6:0]        rdbuf_adr, wrbuf_adr;
  logic [31:0]       rdbuf_dat_w, wrbuf_dat_r;
  logic              rdbuf_we;
  logic              mem_req, mem_we, mem_ack;
  logic [MEM_AW-1:0] mem_adr;
  logic [31:0]       mem_dat_w, mem_dat_r;
  logic              err_out_range, busy;

  logic [31:0] mem   [MEM_WORDS];
  logic [31:0] wrbuf [128];
  logic [31:0] cap   [128];

  int n_checks = 0, n_pass = 0;
  int go_cnt = 0, done_cnt = 0, err_cnt = 0, req_cycles = 0;
  int mem_word = 0, rd_word = 0, ack_wait = 0;
  logic [31:0] first_adr = '0, last_adr = '0;
  logic [31:0] exp_blk = '0;
  logic        exp_we = 1'b0, exp_oor = 1'b0;
  int lit5 [3] = '{261, 389, 517};

  sd_block_mover #(
    .MEM_AW     (MEM_AW),
    .BASE_WORD  (BASE),
    .NUM_BLOCKS (32'd8)
  ) dut (
    .sys_clk           (sys_clk),
    .sys_rst           (sys_rst),
    .block_read_act    (block_read_act),
    .block_read_addr   (block_read_addr),
    .block_read_stop   (block_read_stop),
    .block_read_next   (block_read_next),
    .block_read_go     (block_read_go),
    .block_write_act   (block_write_act),
    .block_write_addr  (block_write_addr),
    .block_write_ready (block_write_ready),
    .block_write_done  (block_write_done),
    .rdbuf_adr         (rdbuf_adr),
    .rdbuf_dat_w       (rdbuf_dat_w),
    .rdbuf_we          (rdbuf_we),
    .wrbuf_adr         (wrbuf_adr),
    .wrbuf_dat_r       (wrbuf_dat_r),
    .mem_req           (mem_req),
    .mem_we            (mem_we),
    .mem_adr           (mem_adr),
    .mem_dat_w         (mem_dat_w),
    .mem_dat_r         (mem_dat_r),
    .mem_ack           (mem_ack),
    .err_out_range     (err_out_range),
    .busy              (busy)
  );

  always #5 sys_clk = ~sys_clk;

  // Write buffer: synchronous RAM with one cycle of read latency.
  always @(posedge sys_clk) wrbuf_dat_r <= wrbuf[wrbuf_adr];

  // Memory: acks ACK_DLY cycles after a request appears, one-cycle ack.
  initial begin
    for (int k = 0; k < MEM_WORDS; k++) mem[k] = k;
    mem[768]  = 32'h1122_3344;
    mem_ack   = 1'b0;
    mem_dat_r = 32'hDEAD_BEEF;
    forever begin
      @(posedge sys_clk);
      #1;
      if (sys_rst) begin
        mem_ack  = 1'b0;
        ack_wait = 0;
      end else if (mem_ack) begin
        mem_ack   = 1'b0;
        ack_wait  = 0;
        mem_dat_r = 32'hDEAD_BEEF;
      end else if (mem_req) begin
        ack_wait++;
        if (ack_wait >= ACK_DLY) begin
          mem_ack = 1'b1;
          if (mem_we) mem[mem_adr] = mem_dat_w;
          else        mem_dat_r = mem[mem_adr];
        end
      end
    end
  end

  function automatic logic [31:0] sw(input logic [31:0] x);
`ifdef SD_BLOCK_BYTESWAP_EN
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
    return x;
`endif
  endfunction

  function automatic int addr_of(input logic [31:0] blk, input int i);
    longint unsigned a = BASE + longint'(blk) * 128 + longint'(i);
    return int'(a % MEM_WORDS);
  endfunction

  function automatic logic [31:0] rd_ref(input int i);
    return exp_oor ? 32'd0 : sw(mem[addr_of(exp_blk, i)]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic new_block(input logic [31:0] blk, input logic we, input logic oor);
    exp_blk  = blk;
    exp_we   = we;
    exp_oor  = oor;
    mem_word = 0;
    rd_word  = 0;
    for (int i = 0; i < 128; i++) cap[i] = 32'hFFFF_FFFF;
  endtask

  task automatic compare();
    int bad;
    if (block_read_go)    go_cnt++;
    if (block_write_done) done_cnt++;
    if (err_out_range) begin
      err_cnt++;
      chk("err_with_pulse", 32'(block_read_go | block_write_done), 32'd1);
    end
    if (mem_req) begin
      req_cycles++;
      chk("mem_we", 32'(mem_we), 32'(exp_we));
    end
    if (mem_req && mem_ack) begin
      chk("mem_adr", 32'(mem_adr), 32'(addr_of(exp_blk, mem_word)));
      if (exp_we) chk("mem_dat_w", mem_dat_w, sw(wrbuf[mem_word[6:0]]));
      if (mem_word == 0) first_adr = 32'(mem_adr);
      last_adr = 32'(mem_adr);
      mem_word++;
    end
    if (rdbuf_we) begin
      chk("rdbuf_adr", 32'(rdbuf_adr), 32'(rd_word));
      chk("rdbuf_dat", rdbuf_dat_w, rd_ref(int'(rdbuf_adr)));
      cap[rdbuf_adr] = rdbuf_dat_w;
      rd_word++;
    end
    if (block_read_go) begin
      bad = 0;
      for (int i = 0; i < 128; i++) if (cap[i] !== rd_ref(i)) bad++;
      chk("go_words", 32'(rd_word), 32'd128);
      chk("go_err", 32'(err_out_range), 32'(exp_oor));
      chk("rdbuf_block", 32'(bad), 32'd0);
      $display("read  blk %0d: words=%0d err=%0d bad=%0d", exp_blk, rd_word, err_out_range, bad);
    end
    if (block_write_done) begin
      bad = 0;
      if (!exp_oor)
        for (int i = 0; i < 128; i++) if (mem[addr_of(exp_blk, i)] !== sw(wrbuf[i])) bad++;
      chk("wr_words", 32'(mem_word), exp_oor ? 32'd0 : 32'd128);
      chk("done_err", 32'(err_out_range), 32'(exp_oor));
      chk("mem_block", 32'(bad), 32'd0);
      $display("write blk %0d: words=%0d err=%0d bad=%0d", exp_blk, mem_word, err_out_range, bad);
    end
  endtask

  // One cycle: compare on the falling edge, then return 2 time units after the rising edge.
  task automatic tick();
    @(negedge sys_clk);
    if (!sys_rst) compare();
    @(posedge sys_clk);
    #2;
  endtask

  function automatic bit cond(input int sel, input int target);
    case (sel)
      0:       return go_cnt >= target;
      1:       return done_cnt >= target;
      2:       return !busy;
      default: return (mem_word == target) && mem_req;
    endcase
  endfunction

  task automatic wait_until(input string name, input int sel, input int target);
    bit ok = 0;
    for (int t = 0; t < 3000 && !ok; t++) begin
      if (cond(sel, target)) ok = 1;
      else tick();
    end
    if (!ok) ok = cond(sel, target);
    chk({name, "_reached"}, 32'(ok), 32'd1);
  endtask

  function automatic logic any_out();
    return |{busy, mem_req, mem_we, mem_adr, mem_dat_w, rdbuf_we, rdbuf_adr, rdbuf_dat_w,
             wrbuf_adr, block_read_go, block_write_done, err_out_range};
  endfunction

  initial begin
    int g0, d0, r0, e0;
    sys_rst = 1'b1;
    {block_read_act, block_read_stop, block_read_next} = '0;
    {block_write_act, block_write_ready} = '0;
    block_read_addr  = '0;
    block_write_addr = '0;
    for (int i = 0; i < 128; i++) wrbuf[i] = '0;
    new_block(0, 0, 0);
    repeat (3) begin @(posedge sys_clk); #2; end
    chk("reset_outputs", 32'(any_out()), 32'd0);
    sys_rst = 1'b0;
    tick();
    chk("idle_after_reset", 32'(busy), 32'd0);

    // Single read of block 5.
    new_block(5, 0, 0);
    g0 = go_cnt;
    block_read_addr = 5;
    block_read_act  = 1'b1;
    wait_until("rd5_go", 0, g0 + 1);
    repeat (4) tick();
    chk("rd5_go_count", 32'(go_cnt - g0), 32'd1);
    chk("rd5_first_adr", first_adr, 32'd640);
    chk("rd5_last_adr", last_adr, 32'd767);
    chk("rd5_cap0", cap[0], sw(32'd640));
    chk("rd5_cap127", cap[127], sw(32'd767));
    chk("rd5_hold_busy", 32'(busy), 32'd1);
    block_read_act = 1'b0;
    wait_until("rd5_idle", 2, 0);

    // Multi-block read 2,3,4 then stop.
    new_block(2, 0, 0);
    g0 = go_cnt;
    block_read_addr = 2;
    block_read_act  = 1'b1;
    wait_until("multi_go0", 0, g0 + 1);
    chk("multi_cap5_0", cap[5], sw(32'(lit5[0])));
    for (int n = 1; n < 3; n++) begin
      new_block(32'(2 + n), 0, 0);
      block_read_next = 1'b1;
      tick();
      block_read_next = 1'b0;
      wait_until("multi_go", 0, g0 + 1 + n);
      chk("multi_cap5", cap[5], sw(32'(lit5[n])));
    end
    block_read_stop = 1'b1;
    tick();
    block_read_stop = 1'b0;
    block_read_act  = 1'b0;
    chk("multi_stop_idle", 32'(busy), 32'd0);
    tick();
    chk("multi_go_count", 32'(go_cnt - g0), 32'd3);

    // Write block 1 with the A5 pattern.
    for (int i = 0; i < 128; i++) wrbuf[i] = 32'hA500_0000 + 32'(i);
    new_block(1, 1, 0);
    block_write_addr = 1;
    block_write_act  = 1'b1;
    tick();
    tick();
    d0 = done_cnt;
    block_write_ready = 1'b1;
    tick();
    block_write_ready = 1'b0;
    wait_until("wr1_done", 1, d0 + 1);
    repeat (3) tick();
    chk("wr1_done_count", 32'(done_cnt - d0), 32'd1);
    chk("wr1_mem128", mem[128], sw(32'hA500_0000));
    chk("wr1_mem255", mem[255], sw(32'hA500_007F));
    chk("wr1_wait_busy", 32'(busy), 32'd1);
    block_write_act = 1'b0;
    wait_until("wr1_idle", 2, 0);

    // Ready outside WR_WAIT is ignored.
    d0 = done_cnt;
    r0 = req_cycles;
    block_write_ready = 1'b1;
    tick();
    block_write_ready = 1'b0;
    repeat (5) tick();
    chk("stray_ready_done", 32'(done_cnt - d0), 32'd0);
    chk("stray_ready_req", 32'(req_cycles - r0), 32'd0);
    chk("stray_ready_busy", 32'(busy), 32'd0);

    // Out-of-range read (block 8 == NUM_BLOCKS).
    new_block(8, 0, 1);
    g0 = go_cnt;
    r0 = req_cycles;
    e0 = err_cnt;
    block_read_addr = 8;
    block_read_act  = 1'b1;
    wait_until("oor_rd_go", 0, g0 + 1);
    repeat (2) tick();
    chk("oor_rd_no_req", 32'(req_cycles - r0), 32'd0);
    chk("oor_rd_err_count", 32'(err_cnt - e0), 32'd1);
    chk("oor_rd_cap77", cap[77], 32'd0);
    block_read_act = 1'b0;
    wait_until("oor_rd_idle", 2, 0);

    // Out-of-range write: done and err one cycle after ready.
    new_block(9, 1, 1);
    r0 = req_cycles;
    block_write_addr = 9;
    block_write_act  = 1'b1;
    tick();
    tick();
    block_write_ready = 1'b1;
    tick();
    block_write_ready = 1'b0;
    chk("oor_wr_done", 32'(block_write_done), 32'd1);
    chk("oor_wr_err", 32'(err_out_range), 32'd1);
    block_write_act = 1'b0;
    tick();
    wait_until("oor_wr_idle", 2, 0);
    chk("oor_wr_no_req", 32'(req_cycles - r0), 32'd0);

    // Asynchronous reset while waiting on word 60 of block 3.
    new_block(3, 0, 0);
    block_read_addr = 3;
    block_read_act  = 1'b1;
    wait_until("rst_word60", 3, 60);
    chk("rst_pre_adr", 32'(mem_adr), 32'd444);
    sys_rst = 1'b1;
    #1;
    chk("rst_outputs", 32'(any_out()), 32'd0);
    block_read_act = 1'b0;
    tick();
    tick();
    sys_rst = 1'b0;
    tick();
    new_block(3, 0, 0);
    g0 = go_cnt;
    block_read_act = 1'b1;
    wait_until("rst_reread_go", 0, g0 + 1);
    chk("rst_reread_first", first_adr, 32'd384);
    block_read_act = 1'b0;
    wait_until("rst_idle", 2, 0);

    // Byte order on both paths.
    new_block(6, 0, 0);
    g0 = go_cnt;
    block_read_addr = 6;
    block_read_act  = 1'b1;
    wait_until("sw_rd_go", 0, g0 + 1);
    chk("sw_rd_word", cap[0], EXP_SW);
    block_read_act = 1'b0;
    wait_until("sw_rd_idle", 2, 0);
    wrbuf[0] = 32'h1122_3344;
    new_block(7, 1, 0);
    d0 = done_cnt;
    block_write_addr = 7;
    block_write_act  = 1'b1;
    tick();
    block_write_ready = 1'b1;
    tick();
    block_write_ready = 1'b0;
    wait_until("sw_wr_done", 1, d0 + 1);
    chk("sw_wr_word", mem[896], EXP_SW);
    block_write_act = 1'b0;
    wait_until("sw_wr_idle", 2, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
